// File: rtl/fast_square_pkg.sv
// Shared constants for the fast-square frequency stepper and its sweep controller.
package fast_square_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STEP   = 2'd1,
      ST_SETTLE = 2'd2
   } state_e;

   localparam int unsigned FREQ_W             = 32;
   localparam int unsigned IDX_W              = 8;
   localparam int unsigned DEF_NUM_FREQ_STEPS = 32;
   localparam int unsigned DEF_SETTLE_TICKS   = 640;
   localparam int unsigned DEF_MIN_HIGH       = 4;

endpackage

// File: rtl/fast_square_pulse_qualifier.sv
// Synchronises the raw step line and emits one step_event per high period
// lasting at least MIN_HIGH synchronised cycles.
module fast_square_pulse_qualifier #(
   parameter int unsigned MIN_HIGH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pulse_in,
   output logic step_event
);

   localparam int unsigned CNT_W = $clog2(MIN_HIGH + 1);

   logic             meta_q, meta_d;
   logic             sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      meta_d = pulse_in;
      sync_d = meta_q;
      cnt_d  = '0;
      if (sync_q) begin
         cnt_d = (cnt_q == CNT_W'(MIN_HIGH)) ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   // Fires on the cycle the high count reaches MIN_HIGH, once per high period.
   assign step_event = sync_q && (cnt_q == CNT_W'(MIN_HIGH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/fast_square_freq_stepper.sv
// LO tuning-word sequencer: one step per qualified pulse, settle plus PLL lock,
// wrap to base with a resync pulse after the last step.
module fast_square_freq_stepper
   import fast_square_pkg::*;
#(
   parameter int unsigned       NUM_FREQ_STEPS = DEF_NUM_FREQ_STEPS,
   parameter logic [FREQ_W-1:0] FREQ_BASE      = 32'h0400_0000,
   parameter logic [FREQ_W-1:0] FREQ_INCR      = 32'h0010_0000,
   parameter int unsigned       MIN_HIGH       = DEF_MIN_HIGH,
   parameter int unsigned       SETTLE_TICKS   = DEF_SETTLE_TICKS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              freq_step_in,
   input  logic              pll_locked,
   output logic [FREQ_W-1:0] freq_word,
   output logic              freq_word_valid,
   output logic [IDX_W-1:0]  step_index,
   output logic              settled,
   output logic              freq_step_reset_out,
   output logic              overrun,
   output logic [3:0]        debug
);

   localparam int unsigned SCNT_W = $clog2(SETTLE_TICKS + 1);

   logic step_event;

   state_e              state_q, state_d;
   logic                pending_q, pending_d;
   logic                overrun_q, overrun_d;
   logic [FREQ_W-1:0]   freq_word_q, freq_word_d;
   logic [IDX_W-1:0]    step_index_q, step_index_d;
   logic                valid_q, valid_d;
   logic                wrap_q, wrap_d;
   logic                settled_q, settled_d;
   logic [SCNT_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic                lock_meta_q, lock_meta_d;
   logic                lock_sync_q, lock_sync_d;

   fast_square_pulse_qualifier #(
      .MIN_HIGH (MIN_HIGH)
   ) u_qualifier (
      .clk        (clock),
      .rst_n      (reset),
      .pulse_in   (freq_step_in),
      .step_event (step_event)
   );

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q | step_event;
      overrun_d    = overrun_q;
      freq_word_d  = freq_word_q;
      step_index_d = step_index_q;
      valid_d      = 1'b0;
      wrap_d       = 1'b0;
      settle_cnt_d = settle_cnt_q;
      lock_meta_d  = pll_locked;
      lock_sync_d  = lock_meta_q;

      case (state_q)
         // The step outputs are registered on entry to STEP so the strobe is high during STEP.
         ST_IDLE: begin
            if (pending_q) begin
               state_d   = ST_STEP;
               pending_d = step_event;
               valid_d   = 1'b1;
               if (step_index_q == IDX_W'(NUM_FREQ_STEPS - 1)) begin
                  step_index_d = '0;
                  freq_word_d  = FREQ_BASE;
                  wrap_d       = 1'b1;
               end else begin
                  step_index_d = step_index_q + IDX_W'(1);
                  freq_word_d  = freq_word_q + FREQ_INCR;
               end
            end
         end
         ST_STEP: begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
         end
         ST_SETTLE: begin
            if (settle_cnt_q >= SCNT_W'(SETTLE_TICKS - 1)) begin
               if (lock_sync_q) begin
                  state_d = ST_IDLE;
               end
            end else begin
               settle_cnt_d = settle_cnt_q + SCNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A second event is lost only when the held one is not being consumed this cycle.
      if (step_event && pending_q && !((state_q == ST_IDLE) && (state_d == ST_STEP))) begin
         overrun_d = 1'b1;
      end

      settled_d = (state_q == ST_IDLE) && (state_d == ST_IDLE) && lock_sync_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         freq_word_q  <= FREQ_BASE;
         step_index_q <= '0;
         valid_q      <= 1'b0;
         wrap_q       <= 1'b0;
         settled_q    <= 1'b0;
         settle_cnt_q <= '0;
         lock_meta_q  <= 1'b0;
         lock_sync_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         freq_word_q  <= freq_word_d;
         step_index_q <= step_index_d;
         valid_q      <= valid_d;
         wrap_q       <= wrap_d;
         settled_q    <= settled_d;
         settle_cnt_q <= settle_cnt_d;
         lock_meta_q  <= lock_meta_d;
         lock_sync_q  <= lock_sync_d;
      end
   end

   assign freq_word           = freq_word_q;
   assign freq_word_valid     = valid_q;
   assign step_index          = step_index_q;
   assign settled             = settled_q;
   assign freq_step_reset_out = wrap_q;
   assign overrun             = overrun_q;
   assign debug               = {2'b00, state_q};

endmodule
